max_score_ctrl: RTL and testbench



---
 rtl/max_score_ctrl.sv | 129 ++++++++++++
 tb/tb_max_score_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_score_ctrl.sv
// max_score_ctrl: drives the 64-lane pipelined max tree and folds its output into a running best score.
// Define MAX_POS_TRACK_EN to also track and report the column of the first maximum on res_col.
module myMax64 #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH*64-1:0] data,
  output logic [DATA_WIDTH-1:0]    result
);
  logic signed [DATA_WIDTH-1:0] grp [8];
  logic signed [DATA_WIDTH-1:0] stg [8];
  logic signed [DATA_WIDTH-1:0] top;
  // seeding every max with zero gives max(lanes, 0)
  always_comb begin
    for (int g = 0; g < 8; g++) begin
      grp[g] = '0;
      for (int l = 0; l < 8; l++)
        grp[g] = ($signed(data[DATA_WIDTH*(8*g+l) +: DATA_WIDTH]) > grp[g]) ? data[DATA_WIDTH*(8*g+l) +: DATA_WIDTH] : grp[g];
    end
  end
  always_comb begin
    top = '0;
    for (int g = 0; g < 8; g++)
      top = (stg[g] > top) ? stg[g] : top;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg    <= '{default: '0};
      result <= '0;
    end else begin
      stg    <= grp;
      result <= top;
    end
  end
endmodule

module max_score_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 64,
  parameter int COL_W      = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*LANES-1:0] in_score,
  input  logic [COL_W-1:0]            in_col,
  input  logic                        in_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_WIDTH-1:0]       res_score,
`ifdef MAX_POS_TRACK_EN
  output logic [COL_W-1:0]            res_col,
`endif
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  state_t state, state_nx;
  logic accept, clr, upd;
  logic s1_v, s1_last, s2_v, s2_last;
  logic [DATA_WIDTH-1:0] tree_out, best;
  assign in_ready  = state == RUN;
  assign res_valid = state == HOLD;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign accept    = in_valid & in_ready;
  assign res_score = best;
  assign upd       = s2_v & ($signed(tree_out) > $signed(best));
  myMax64 #(.DATA_WIDTH(DATA_WIDTH)) u_tree (
    .clk    (clk),
    .rst_n  (~rst),
    .data   (in_score),
    .result (tree_out)
  );
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        state_nx = start ? RUN : IDLE;
        clr      = start;
      end
      RUN:   state_nx = (accept & in_last) ? DRAIN : RUN;
      DRAIN: state_nx = (s2_v & s2_last) ? HOLD : DRAIN;
      HOLD: begin
        state_nx = res_ready ? (start ? RUN : IDLE) : HOLD;
        clr      = res_ready & start;
      end
      default: state_nx = IDLE;
    endcase
  end
  // shadow pipe tracks which tree outputs carry real vectors
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_last <= 1'b0;
      s2_last <= 1'b0;
      best    <= '0;
    end else begin
      state   <= state_nx;
      s1_v    <= accept;
      s2_v    <= s1_v;
      s1_last <= in_last;
      s2_last <= s1_last;
      best    <= clr ? '0 : (upd ? tree_out : best);
    end
  end
`ifdef MAX_POS_TRACK_EN
  logic [COL_W-1:0] s1_col, s2_col, best_col;
  assign res_col = best_col;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_col   <= '0;
      s2_col   <= '0;
      best_col <= '0;
    end else begin
      s1_col   <= in_col;
      s2_col   <= s1_col;
      best_col <= clr ? '0 : (upd ? s2_col : best_col);
    end
  end
`else
  logic unused_col;
  assign unused_col = ^in_col;
`endif
endmodule

// File: tb/tb_max_score_ctrl.sv
// tb_max_score_ctrl: directed and random alignments checked against a queue-based best-score model.
module tb_max_score_ctrl;
  localparam int DW = 18;
  localparam int CW = 13;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [DW*64-1:0] in_score = '0;
  logic [CW-1:0] in_col = '0;
  logic in_ready, res_valid, busy;
  logic [DW-1:0] res_score;
  logic [CW-1:0] res_col_w;
  int n_checks = 0, n_fails = 0;
  logic [DW*64-1:0] vecs [$];
  int cols [$];

  max_score_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_col(in_col), .in_last(in_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_score(res_score),
`ifdef MAX_POS_TRACK_EN
    .res_col(res_col_w),
`endif
    .busy(busy)
  );
`ifndef MAX_POS_TRACK_EN
  assign res_col_w = '0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mkvec(input int mx, input int col, input bit rnd, input int other);
    logic [DW*64-1:0] v;
    int pos, x;
    pos = $urandom_range(0, 63);
    for (int i = 0; i < 64; i++) begin
      x = (i == pos) ? mx : (rnd ? mx - 1 - int'($urandom_range(0, 300)) : other);
      v[DW*i +: DW] = x[DW-1:0];
    end
    vecs.push_back(v);
    cols.push_back(col);
  endtask

  // first strictly greater value wins, starting from a zero best
  task automatic model(output int b, output int c);
    logic signed [DW-1:0] s;
    b = 0;
    c = 0;
    for (int k = 0; k < vecs.size(); k++)
      for (int i = 0; i < 64; i++) begin
        s = vecs[k][DW*i +: DW];
        if (int'(s) > b) begin
          b = int'(s);
          c = cols[k];
        end
      end
  endtask

  task automatic begin_align();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ready", {31'b0, in_ready}, 32'd1);
    check("start_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic feed(input bit bub);
    for (int i = 0; i < vecs.size(); i++) begin
      if (bub && (i % 2 == 1)) begin
        in_valid = 1'b0;
        tick();
        check("bubble_ready", {31'b0, in_ready}, 32'd1);
      end
      in_valid = 1'b1;
      in_score = vecs[i];
      in_col   = cols[i][CW-1:0];
      in_last  = (i == vecs.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input int hold, input bit b2b);
    int eb, ec, n;
    model(eb, ec);
    n = 1;
    res_ready = 1'b1;
    while (!res_valid && n < 10) begin
      check("drain_ready", {31'b0, in_ready}, 32'd0);
      tick();
      n++;
    end
    check("latency", n, 32'd3);
    check("res_valid", {31'b0, res_valid}, 32'd1);
    check("res_score", {14'b0, res_score}, eb);
    check("hold_ready", {31'b0, in_ready}, 32'd0);
    check("hold_busy", {31'b0, busy}, 32'd0);
`ifdef MAX_POS_TRACK_EN
    check("res_col", {19'b0, res_col_w}, ec);
`endif
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("held_valid", {31'b0, res_valid}, 32'd1);
      check("held_score", {14'b0, res_score}, eb);
`ifdef MAX_POS_TRACK_EN
      check("held_col", {19'b0, res_col_w}, ec);
`endif
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    start = b2b;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    check("post_valid", {31'b0, res_valid}, 32'd0);
    check("post_ready", {31'b0, in_ready}, {31'b0, b2b});
    vecs.delete();
    cols.delete();
  endtask

  initial begin
    int n, hold;
    bit b2b, in_run;
    tick();
    tick();
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_score", {14'b0, res_score}, 32'd0);
    check("rst_col", {19'b0, res_col_w}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'b0, in_ready}, 32'd0);
    // single vector, lane value 500 among 10s
    begin_align();
    mkvec(500, 5, 1'b0, 10);
    feed(1'b0);
    expect_result(2, 1'b0);
    // tie keeps earliest column
    begin_align();
    mkvec(100, 0, 1'b1, 0);
    mkvec(300, 1, 1'b1, 0);
    mkvec(300, 2, 1'b1, 0);
    feed(1'b0);
    expect_result(1, 1'b0);
    // all lanes -1
    begin_align();
    mkvec(-1, 3, 1'b0, -1);
    mkvec(-1, 4, 1'b0, -1);
    feed(1'b0);
    expect_result(0, 1'b0);
    // bubbles and long hold
    begin_align();
    mkvec(7, 10, 1'b1, 0);
    mkvec(9, 11, 1'b1, 0);
    mkvec(2, 12, 1'b1, 0);
    mkvec(9, 13, 1'b1, 0);
    mkvec(1, 14, 1'b1, 0);
    mkvec(4, 15, 1'b1, 0);
    feed(1'b1);
    expect_result(5, 1'b0);
    // reset right after the last accept discards the in-flight result
    begin_align();
    mkvec(777, 6, 1'b1, 0);
    feed(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_mid_valid", {31'b0, res_valid}, 32'd0);
    end
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_score", {14'b0, res_score}, 32'd0);
    vecs.delete();
    cols.delete();
    begin_align();
    mkvec(42, 7, 1'b1, 0);
    feed(1'b0);
    expect_result(0, 1'b0);
    // back-to-back alignments
    begin_align();
    mkvec(900, 8, 1'b1, 0);
    feed(1'b0);
    expect_result(0, 1'b1);
    mkvec(11, 9, 1'b1, 0);
    feed(1'b0);
    expect_result(0, 1'b0);
    // random alignments
    in_run = 1'b0;
    for (int a = 0; a < 25; a++) begin
      if (!in_run) begin_align();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++)
        mkvec(int'($urandom_range(0, 3000)) - 600, int'($urandom_range(0, 8191)), 1'b1, 0);
      feed(1'($urandom_range(0, 1)));
      hold = $urandom_range(0, 3);
      b2b = (a < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      expect_result(hold, b2b);
      in_run = b2b;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
